// File: rtl/pc_pkg.sv
// pc_pkg: address width, return-stack depth and address type shared by the PC and the return stack
package pc_pkg;
  localparam int ADDR_W = 12;
  localparam int RAS_DEPTH = 8;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/ras_regfile.sv
// ras_regfile: DEPTH x D register array, one write port (i_we/i_waddr/i_wdata), one async read port (i_raddr/o_rdata), no reset
module ras_regfile
  import pc_pkg::*;
#(
  parameter int D = ADDR_W,
  parameter int DEPTH = RAS_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [D-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [D-1:0]  o_rdata
);
  logic [D-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/return_addr_stack.sv
// return_addr_stack: circular LIFO of link addresses; push_en/push_addr/pop_en/clear_err in, top_addr/top_valid/count/full/overflow/underflow out
module return_addr_stack
  import pc_pkg::*;
#(
  parameter int D = ADDR_W,
  parameter int DEPTH = RAS_DEPTH,
  localparam int SW = $clog2(DEPTH),
  localparam int CW = SW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_en,
  input  logic [D-1:0]  push_addr,
  input  logic          pop_en,
  input  logic          clear_err,
  output logic [D-1:0]  top_addr,
  output logic          top_valid,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);
  localparam logic [SW-1:0] SP_ONE = SW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  logic [SW-1:0] r_sp, w_top_idx, w_waddr;
  logic [CW-1:0] r_count;
  logic          r_ovf, r_unf;
  logic          w_empty, w_we, w_ovf_evt, w_unf_evt;
  logic [D-1:0]  w_rdata;
  assign w_empty   = r_count == '0;
  assign w_top_idx = r_sp - SP_ONE;
  assign w_we      = push_en & ~(pop_en & w_empty) & ~reset;
  assign w_waddr   = pop_en ? w_top_idx : r_sp;
  assign w_ovf_evt = push_en & ~pop_en & full;
  assign w_unf_evt = pop_en & w_empty;
  ras_regfile #(.D(D), .DEPTH(DEPTH)) u_regfile (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (push_addr),
    .i_raddr (w_top_idx),
    .o_rdata (w_rdata)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_sp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (push_en & ~pop_en) begin
        r_sp    <= r_sp + SP_ONE;
        r_count <= full ? r_count : r_count + CNT_ONE;
      end else if (pop_en & ~push_en & ~w_empty) begin
        r_sp    <= w_top_idx;
        r_count <= r_count - CNT_ONE;
      end
      r_ovf <= w_ovf_evt | (r_ovf & ~clear_err);
      r_unf <= w_unf_evt | (r_unf & ~clear_err);
    end
  assign full      = r_count == CNT_FULL;
  assign top_valid = ~w_empty;
  assign top_addr  = w_empty ? '0 : w_rdata;
  assign count     = r_count;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
endmodule

// File: tb/tb_return_addr_stack.sv
// tb_return_addr_stack: table vectors, corner sequences and randomized queue-model check of return_addr_stack
module tb_return_addr_stack;
  localparam int D = 12;
  localparam int DEPTH = 8;
  typedef struct {
    string       name;
    logic        push;
    logic [D-1:0] addr;
    logic        pop;
    logic        clr;
    logic [D-1:0] top;
    logic        valid;
    logic [3:0]  cnt;
    logic        full;
    logic        ovf;
    logic        unf;
  } vec_t;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         push_en = 1'b0;
  logic [D-1:0] push_addr = '0;
  logic         pop_en = 1'b0;
  logic         clear_err = 1'b0;
  logic [D-1:0] top_addr;
  logic         top_valid;
  logic [3:0]   count;
  logic         full;
  logic         overflow;
  logic         underflow;
  int vectors = 0;
  int miscompares = 0;
  vec_t tv[$];
  int q[$];
  logic m_ovf, m_unf;
  return_addr_stack #(.D(D), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .push_en   (push_en),
    .push_addr (push_addr),
    .pop_en    (pop_en),
    .clear_err (clear_err),
    .top_addr  (top_addr),
    .top_valid (top_valid),
    .count     (count),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(string n, logic p, logic [D-1:0] a, logic po, logic c,
                              logic [D-1:0] t, logic v, logic [3:0] cn, logic f, logic o, logic u);
    vec_t x;
    x.name = n; x.push = p; x.addr = a; x.pop = po; x.clr = c;
    x.top = t; x.valid = v; x.cnt = cn; x.full = f; x.ovf = o; x.unf = u;
    return x;
  endfunction
  task automatic chk(string n, logic [D-1:0] t, logic v, logic [3:0] cn, logic f, logic o, logic u);
    vectors++;
    if (top_addr !== t || top_valid !== v || count !== cn || full !== f || overflow !== o || underflow !== u) begin
      miscompares++;
      $display("FAIL %s: got top=%h valid=%b count=%0d full=%b ovf=%b unf=%b, want top=%h valid=%b count=%0d full=%b ovf=%b unf=%b",
               n, top_addr, top_valid, count, full, overflow, underflow, t, v, cn, f, o, u);
    end
  endtask
  task automatic step(logic p, logic [D-1:0] a, logic po, logic c);
    push_en = p; push_addr = a; pop_en = po; clear_err = c;
    @(posedge clk);
    #1;
    push_en = 1'b0; pop_en = 1'b0; clear_err = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  initial begin
    tv.push_back(mk("push10",   1, 12'h010, 0, 0, 12'h010, 1, 1, 0, 0, 0));
    tv.push_back(mk("push20",   1, 12'h020, 0, 0, 12'h020, 1, 2, 0, 0, 0));
    tv.push_back(mk("push30",   1, 12'h030, 0, 0, 12'h030, 1, 3, 0, 0, 0));
    tv.push_back(mk("pop_a",    0, 12'h000, 1, 0, 12'h020, 1, 2, 0, 0, 0));
    tv.push_back(mk("pop_b",    0, 12'h000, 1, 0, 12'h010, 1, 1, 0, 0, 0));
    tv.push_back(mk("pop_last", 0, 12'h000, 1, 0, 12'h000, 0, 0, 0, 0, 0));
    tv.push_back(mk("pop_empty",0, 12'h000, 1, 0, 12'h000, 0, 0, 0, 0, 1));
    tv.push_back(mk("clr_unf",  0, 12'h000, 0, 1, 12'h000, 0, 0, 0, 0, 0));
    tv.push_back(mk("pp_empty", 1, 12'h0aa, 1, 0, 12'h000, 0, 0, 0, 0, 1));
    tv.push_back(mk("clr_vs_evt",0,12'h000, 1, 1, 12'h000, 0, 0, 0, 0, 1));
    tv.push_back(mk("clr_unf2", 0, 12'h000, 0, 1, 12'h000, 0, 0, 0, 0, 0));
    tv.push_back(mk("push30b",  1, 12'h030, 0, 0, 12'h030, 1, 1, 0, 0, 0));
    tv.push_back(mk("push40",   1, 12'h040, 0, 0, 12'h040, 1, 2, 0, 0, 0));
    tv.push_back(mk("pp_repl",  1, 12'h055, 1, 0, 12'h055, 1, 2, 0, 0, 0));
    tv.push_back(mk("pop_repl", 0, 12'h000, 1, 0, 12'h030, 1, 1, 0, 0, 0));
    tv.push_back(mk("pop_repl2",0, 12'h000, 1, 0, 12'h000, 0, 0, 0, 0, 0));
    for (int i = 0; i < 9; i++)
      tv.push_back(mk($sformatf("ovf_push%0d", i), 1, D'(12'h101 + i), 0, 0, D'(12'h101 + i), 1,
                      4'((i + 1 > DEPTH) ? DEPTH : i + 1), i >= DEPTH - 1, i == DEPTH, 0));
    for (int k = 1; k <= DEPTH; k++)
      tv.push_back(mk($sformatf("ovf_pop%0d", k), 0, 12'h000, 1, 0, (k == DEPTH) ? 12'h000 : D'(12'h109 - k),
                      k < DEPTH, 4'(DEPTH - k), 0, 1, 0));
    tv.push_back(mk("clr_ovf",  0, 12'h000, 0, 1, 12'h000, 0, 0, 0, 0, 0));
    do_reset();
    chk("reset_state", 12'h000, 0, 0, 0, 0, 0);
    foreach (tv[i]) begin
      step(tv[i].push, tv[i].addr, tv[i].pop, tv[i].clr);
      chk(tv[i].name, tv[i].top, tv[i].valid, tv[i].cnt, tv[i].full, tv[i].ovf, tv[i].unf);
    end
    // fill, replace top while full: no overflow expected
    for (int i = 0; i < DEPTH; i++) step(1, D'(12'h200 + i), 0, 0);
    step(1, 12'h2ff, 1, 0);
    chk("pp_full", 12'h2ff, 1, 4'(DEPTH), 1, 0, 0);
    // async reset mid-cycle at count 5 with a push held through reset
    do_reset();
    step(0, 12'h000, 1, 0);
    for (int i = 0; i < 5; i++) step(1, D'(12'h300 + i), 0, 0);
    chk("pre_async", 12'h304, 1, 5, 0, 0, 1);
    push_en = 1'b1; push_addr = 12'h777;
    #2 reset = 1'b1;
    #1 chk("async_rst", 12'h000, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 chk("rst_hold_push", 12'h000, 0, 0, 0, 0, 0);
    reset = 1'b0; push_en = 1'b0;
    @(posedge clk);
    #1 chk("post_rst", 12'h000, 0, 0, 0, 0, 0);
    // randomized run against a queue model
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      logic p, po, c;
      logic [D-1:0] a;
      p  = $urandom_range(0, 99) < 50;
      po = $urandom_range(0, 99) < 45;
      c  = $urandom_range(0, 99) < 8;
      a  = D'($urandom);
      if (c) begin m_ovf = 1'b0; m_unf = 1'b0; end
      if (p && po) begin
        if (q.size() > 0) q[q.size() - 1] = int'(a); else m_unf = 1'b1;
      end else if (p) begin
        if (q.size() == DEPTH) begin void'(q.pop_front()); m_ovf = 1'b1; end
        q.push_back(int'(a));
      end else if (po) begin
        if (q.size() > 0) void'(q.pop_back()); else m_unf = 1'b1;
      end
      step(p, a, po, c);
      chk($sformatf("rand%0d", n), (q.size() > 0) ? D'(q[q.size() - 1]) : '0, q.size() > 0,
          4'(q.size()), q.size() == DEPTH, m_ovf, m_unf);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
